// File: rtl/bubble_sort_pkg.sv
// Shared types for the sequential odd-even transposition sorter.
// Optional tag tracking is enabled by BUBBLE_SORT_SEQ_IDX_EN.
package bubble_sort_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } sort_state_e;

  // $clog2(1) is 0, so keep at least one bit.
  function automatic int IDX_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bubble_sort_seq_cmp_swap.sv
// One compare-exchange cell: lo/hi are the lower/higher index slots.
// Tag pass-through exists only with BUBBLE_SORT_SEQ_IDX_EN.
module cmp_swap #(
  parameter int DATA_W = 4
`ifdef BUBBLE_SORT_SEQ_IDX_EN
  , parameter int TAG_W = 3
`endif
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              desc,
`ifdef BUBBLE_SORT_SEQ_IDX_EN
  input  logic [TAG_W-1:0]  tag_a,
  input  logic [TAG_W-1:0]  tag_b,
  output logic [TAG_W-1:0]  tag_lo,
  output logic [TAG_W-1:0]  tag_hi,
`endif
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi,
  output logic              swapped
);

  // Strict compare keeps equal keys in place.
  assign swapped = desc ? (a < b) : (a > b);
  assign lo = swapped ? b : a;
  assign hi = swapped ? a : b;

`ifdef BUBBLE_SORT_SEQ_IDX_EN
  assign tag_lo = swapped ? tag_b : tag_a;
  assign tag_hi = swapped ? tag_a : tag_b;
`endif

endmodule

// File: rtl/bubble_sort_seq.sv
// Handshaked odd-even transposition sorter, one phase per clock.
// Define BUBBLE_SORT_SEQ_IDX_EN for the idx_o original-index output.
module bubble_sort_seq
  import bubble_sort_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DATA_N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              desc_in,
  input  logic [DATA_W-1:0] data_in [DATA_N],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_o [DATA_N]
`ifdef BUBBLE_SORT_SEQ_IDX_EN
  , output logic [IDX_W(DATA_N)-1:0] idx_o [DATA_N]
`endif
);

  localparam int IW = IDX_W(DATA_N);
  localparam logic [IW-1:0] LAST = IW'(DATA_N - 1);

  sort_state_e state, state_n;

  logic [DATA_W-1:0] data [DATA_N];
  logic [DATA_W-1:0] nxt  [DATA_N];
  logic [DATA_W-1:0] lo   [DATA_N-1];
  logic [DATA_W-1:0] hi   [DATA_N-1];
  logic [DATA_N-2:0] sw;
  logic [IW-1:0]     p;
  logic              dir;

`ifdef BUBBLE_SORT_SEQ_IDX_EN
  logic [IW-1:0] tag     [DATA_N];
  logic [IW-1:0] tag_nxt [DATA_N];
  logic [IW-1:0] tag_lo  [DATA_N-1];
  logic [IW-1:0] tag_hi  [DATA_N-1];
`endif

  for (genvar g = 0; g < DATA_N - 1; g++) begin : g_cell
    cmp_swap #(
      .DATA_W (DATA_W)
`ifdef BUBBLE_SORT_SEQ_IDX_EN
      , .TAG_W (IW)
`endif
    ) u_cs (
      .a       (data[g]),
      .b       (data[g+1]),
      .desc    (dir),
`ifdef BUBBLE_SORT_SEQ_IDX_EN
      .tag_a   (tag[g]),
      .tag_b   (tag[g+1]),
      .tag_lo  (tag_lo[g]),
      .tag_hi  (tag_hi[g]),
`endif
      .lo      (lo[g]),
      .hi      (hi[g]),
      .swapped (sw[g])
    );
  end

  // Only pairs whose lower index parity matches p[0] are active.
  always_comb begin
    nxt = data;
`ifdef BUBBLE_SORT_SEQ_IDX_EN
    tag_nxt = tag;
`endif
    for (int i = 0; i < DATA_N - 1; i++) begin
      if ((i % 2) == int'(p[0]) && sw[i]) begin
        nxt[i]   = lo[i];
        nxt[i+1] = hi[i];
`ifdef BUBBLE_SORT_SEQ_IDX_EN
        tag_nxt[i]   = tag_lo[i];
        tag_nxt[i+1] = tag_hi[i];
`endif
      end
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = SORT;
      end
      SORT: begin
        if (p == LAST) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DATA_N; i++) data[i] <= '0;
      dir <= 1'b0;
      p   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            data <= data_in;
            dir  <= desc_in;
            p    <= '0;
          end
        end
        SORT: begin
          data <= nxt;
          p    <= p + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign data_o = data;

`ifdef BUBBLE_SORT_SEQ_IDX_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DATA_N; i++) tag[i] <= IW'(i);
    end else if (state == IDLE && in_valid) begin
      for (int i = 0; i < DATA_N; i++) tag[i] <= IW'(i);
    end else if (state == SORT) begin
      tag <= tag_nxt;
    end
  end

  assign idx_o = tag;
`endif

endmodule

// File: tb/tb_bubble_sort_seq.sv
// Directed bench for bubble_sort_seq (DATA_W=4, DATA_N=8).
// idx_o checks are active when BUBBLE_SORT_SEQ_IDX_EN is defined.
module tb_bubble_sort_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       desc_in;
  logic [3:0] data_in [8];
  logic       out_valid;
  logic       out_ready;
  logic [3:0] data_o [8];
`ifdef BUBBLE_SORT_SEQ_IDX_EN
  logic [2:0] idx_o [8];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bubble_sort_seq #(.DATA_W(4), .DATA_N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .desc_in   (desc_in),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_o    (data_o)
`ifdef BUBBLE_SORT_SEQ_IDX_EN
    , .idx_o   (idx_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Element 0 sits in the top nibble so hex reads in index order.
  task automatic put(input logic [31:0] v);
    for (int i = 0; i < 8; i++) data_in[i] = v[31-4*i -: 4];
  endtask

  function automatic logic [31:0] dpk();
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[31-4*i -: 4] = data_o[i];
    return r;
  endfunction

`ifdef BUBBLE_SORT_SEQ_IDX_EN
  function automatic logic [31:0] ipk();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[23-3*i -: 3] = idx_o[i];
    return r;
  endfunction
`endif

  // Accept one array, then count cycles until out_valid.
  task automatic send(input string tag, input logic [31:0] v,
                      input logic d);
    int n;
    put(v);
    desc_in  = d;
    in_valid = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd8);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, "_irdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_ov0"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    desc_in = 1'b0;
    put(32'h0);
    tick;
    tick;
    rst = 1'b0;
    chk("rst_irdy", 32'(in_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_data", dpk(), 32'h0);
`ifdef BUBBLE_SORT_SEQ_IDX_EN
    chk("rst_idx", ipk(), 32'({3'd0, 3'd1, 3'd2, 3'd3,
                               3'd4, 3'd5, 3'd6, 3'd7}));
`endif

    send("asc", 32'h3710F882, 1'b0);
    chk("asc_data", dpk(), 32'h0123788F);
`ifdef BUBBLE_SORT_SEQ_IDX_EN
    chk("asc_idx", ipk(), 32'({3'd3, 3'd2, 3'd7, 3'd0,
                               3'd1, 3'd5, 3'd6, 3'd4}));
`endif
    drain("asc");

    send("dsc", 32'h3710F882, 1'b1);
    chk("dsc_data", dpk(), 32'hF8873210);
`ifdef BUBBLE_SORT_SEQ_IDX_EN
    chk("dsc_idx", ipk(), 32'({3'd4, 3'd5, 3'd6, 3'd1,
                               3'd0, 3'd7, 3'd2, 3'd3}));
`endif
    drain("dsc");

    send("rev", 32'hFEDCBA98, 1'b0);
    chk("rev_data", dpk(), 32'h89ABCDEF);
    drain("rev");

    send("srt", 32'h0123788F, 1'b0);
    chk("srt_data", dpk(), 32'h0123788F);
    drain("srt");

    // Backpressure with a competing input that must be ignored.
    send("bp", 32'h3710F882, 1'b0);
    put(32'hAAAA_AAAA);
    desc_in  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_data", dpk(), 32'h0123788F);
      chk("bp_irdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    drain("bp");

    // Abort three phases into a sort.
    put(32'hFEDCBA98);
    desc_in  = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("ab_ov", 32'(out_valid), 32'd0);
    chk("ab_irdy", 32'(in_ready), 32'd1);
    chk("ab_data", dpk(), 32'h0);
    send("post", 32'h94C01E63, 1'b0);
    chk("post_data", dpk(), 32'h013469CE);
    drain("post");

    send("eq", 32'h55555555, 1'b0);
    chk("eq_data", dpk(), 32'h55555555);
`ifdef BUBBLE_SORT_SEQ_IDX_EN
    chk("eq_idx", ipk(), 32'({3'd0, 3'd1, 3'd2, 3'd3,
                              3'd4, 3'd5, 3'd6, 3'd7}));
`endif
    drain("eq");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
